// File: rtl/operand_entry_ctrl.sv
// Keypad-to-adder sequencer: builds two decimal operands, launches one addition,
// and selects the value shown on the display.
module operand_entry_ctrl #(
    parameter int DIGITS  = 3,
    parameter int WIDTH   = 10,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             add_done,
    input  logic [WIDTH:0]   sum_in,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             add_start,
    output logic [WIDTH:0]   result,
    output logic [WIDTH:0]   disp_value,
    output logic [2:0]       state_out,
    output logic             entry_full,
    output logic             err
);

    // state   | meaning
    // ENTER_A | collecting digits of operand A
    // ENTER_B | collecting digits of operand B
    // START   | one-cycle add_start launch
    // WAIT    | waiting for add_done or timeout
    // SHOW    | displaying result (or timeout error)
    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] DIGITS_C = CNT_W'(DIGITS);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   digit_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               is_digit, is_enter, is_clear;
    logic               have_digits, can_digit, tmo_hit;
    logic [WIDTH-1:0]   digit_ext, cur_op, next_op;

    assign is_digit    = key_valid && (key_code <= 4'd9);
    assign is_enter    = key_valid && (key_code == 4'hA);
    assign is_clear    = key_valid && (key_code == 4'hB);
    assign have_digits = (digit_cnt != '0);
    assign can_digit   = (digit_cnt < DIGITS_C);
    assign tmo_hit     = (tmo_cnt == '0);
    assign digit_ext   = WIDTH'(key_code);
    assign cur_op      = (state == ENTER_B) ? op_b : op_a;
    // x*10 + d without a multiplier, truncated to the operand width
    assign next_op     = (cur_op << 3) + (cur_op << 1) + digit_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ENTER_A;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (is_clear) begin
            state_nxt = ENTER_A;
        end else begin
            case (state)
                ENTER_A: if (is_enter && have_digits) state_nxt = ENTER_B;
                ENTER_B: if (is_enter && have_digits) state_nxt = START;
                START:   state_nxt = WAIT;
                WAIT:    if (add_done || tmo_hit) state_nxt = SHOW;
                SHOW:    if (is_digit) state_nxt = ENTER_A;
                default: state_nxt = ENTER_A;
            endcase
        end
    end

    always_comb begin
        disp_value = {1'b0, op_b};
        entry_full = 1'b0;
        case (state)
            ENTER_A: disp_value = {1'b0, op_a};
            SHOW:    disp_value = result;
            default: disp_value = {1'b0, op_b};
        endcase
        if ((state == ENTER_A || state == ENTER_B) && digit_cnt == DIGITS_C)
            entry_full = 1'b1;
    end

    assign state_out = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            result    <= '0;
            digit_cnt <= '0;
            tmo_cnt   <= '0;
            add_start <= 1'b0;
            err       <= 1'b0;
        end else begin
            // START lasts exactly one cycle, so this yields a single pulse
            add_start <= (state_nxt == START);
            if (is_clear) begin
                op_a      <= '0;
                op_b      <= '0;
                result    <= '0;
                digit_cnt <= '0;
                err       <= 1'b0;
            end else begin
                case (state)
                    ENTER_A: begin
                        if (is_digit && can_digit) begin
                            op_a      <= next_op;
                            digit_cnt <= digit_cnt + 1'b1;
                        end else if (is_enter && have_digits) begin
                            op_b      <= '0;
                            digit_cnt <= '0;
                        end
                    end
                    ENTER_B: begin
                        if (is_digit && can_digit) begin
                            op_b      <= next_op;
                            digit_cnt <= digit_cnt + 1'b1;
                        end
                    end
                    START: tmo_cnt <= TMO_LOAD;
                    WAIT: begin
                        if (add_done)     result  <= sum_in;
                        else if (tmo_hit) err     <= 1'b1;
                        else              tmo_cnt <= tmo_cnt - 1'b1;
                    end
                    SHOW: begin
                        if (is_digit) begin
                            op_a      <= digit_ext;
                            op_b      <= '0;
                            digit_cnt <= CNT_W'(1);
                            err       <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Randomized and directed bench for operand_entry_ctrl against a behavioural model.
module tb_operand_entry_ctrl;

    localparam int DIGITS  = 3;
    localparam int WIDTH   = 10;
    localparam int TIMEOUT = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             key_valid;
    logic [3:0]       key_code;
    logic             add_done;
    logic [WIDTH:0]   sum_in;
    logic [WIDTH-1:0] op_a, op_b;
    logic             add_start;
    logic [WIDTH:0]   result, disp_value;
    logic [2:0]       state_out;
    logic             entry_full, err;

    operand_entry_ctrl #(.DIGITS(DIGITS), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .add_done(add_done), .sum_in(sum_in), .op_a(op_a), .op_b(op_b),
        .add_start(add_start), .result(result), .disp_value(disp_value),
        .state_out(state_out), .entry_full(entry_full), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int start_pulses = 0;

    // model: 0 enter A, 1 enter B, 2 launch, 3 waiting, 4 showing
    int m_state, m_a, m_b, m_res, m_cnt, m_err, m_tmo, m_start;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_a = 0; m_b = 0; m_res = 0;
        m_cnt = 0; m_err = 0; m_tmo = 0; m_start = 0;
    endtask

    task automatic model_step(input int kv, input int kc, input int ad, input int si);
        if (kv == 1 && kc == 11) begin
            model_reset();
        end else begin
            case (m_state)
                0, 1: begin
                    if (kv == 1 && kc <= 9 && m_cnt < DIGITS) begin
                        if (m_state == 0) m_a = (m_a * 10 + kc) % (1 << WIDTH);
                        else              m_b = (m_b * 10 + kc) % (1 << WIDTH);
                        m_cnt++;
                    end else if (kv == 1 && kc == 10 && m_cnt > 0) begin
                        if (m_state == 0) begin
                            m_state = 1; m_b = 0; m_cnt = 0;
                        end else begin
                            m_state = 2;
                        end
                    end
                end
                2: begin
                    m_state = 3; m_tmo = 0;
                end
                3: begin
                    if (ad == 1) begin
                        m_res = si; m_state = 4;
                    end else if (m_tmo == TIMEOUT - 1) begin
                        m_err = 1; m_state = 4;
                    end else begin
                        m_tmo++;
                    end
                end
                default: begin
                    if (kv == 1 && kc <= 9) begin
                        m_state = 0; m_a = kc; m_b = 0; m_cnt = 1; m_err = 0;
                    end
                end
            endcase
        end
        m_start = (m_state == 2) ? 1 : 0;
    endtask

    task automatic check_all();
        int exp_disp;
        if (m_state == 0)      exp_disp = m_a;
        else if (m_state == 4) exp_disp = m_res;
        else                   exp_disp = m_b;
        check("state", 32'(state_out), m_state);
        check("op_a", 32'(op_a), m_a);
        check("op_b", 32'(op_b), m_b);
        check("result", 32'(result), m_res);
        check("add_start", 32'(add_start), m_start);
        check("err", 32'(err), m_err);
        check("disp_value", 32'(disp_value), exp_disp);
        check("entry_full", 32'(entry_full), (m_state <= 1 && m_cnt == DIGITS) ? 1 : 0);
    endtask

    task automatic step(input int kv, input int kc, input int ad, input int si);
        @(negedge clk);
        key_valid = kv[0];
        key_code  = kc[3:0];
        add_done  = ad[0];
        sum_in    = si[WIDTH:0];
        @(posedge clk);
        #1;
        model_step(kv, kc, ad, si);
        check_all();
        if (add_start) start_pulses++;
    endtask

    task automatic press(input int kc);
        step(1, kc, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        key_valid = 1'b0;
        add_done  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; add_done = 1'b0; sum_in = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // basic launch with a 3-cycle adder response
        start_pulses = 0;
        press(1); press(2); press(3); press(10); press(4); press(5); press(10);
        check("t1_add_start", 32'(add_start), 1);
        check("t1_op_a", 32'(op_a), 123);
        check("t1_op_b", 32'(op_b), 45);
        idle(3);
        step(0, 0, 1, 168);
        check("t1_state", 32'(state_out), 4);
        check("t1_result", 32'(result), 168);
        check("t1_disp", 32'(disp_value), 168);
        check("t1_pulses", start_pulses, 1);

        // digit limit and zero operand B
        press(11);
        press(9); press(9); press(9);
        check("t2_full", 32'(entry_full), 1);
        press(7);
        check("t2_op_a", 32'(op_a), 999);
        press(10); press(0); press(10);
        check("t2_start", 32'(add_start), 1);
        step(0, 0, 1, 999);
        step(0, 0, 1, 999);

        // empty enters and ignored codes in every state
        press(11);
        press(10); press(12); press(15);
        press(1); press(10); press(10); press(13); press(14);
        press(2); press(10); press(12);
        press(13); press(14);
        step(0, 0, 1, 3);
        press(15); press(10); press(12);

        // timeout: SHOW exactly TIMEOUT cycles after entering WAIT
        press(11);
        press(1); press(10); press(2); press(10);
        step(0, 0, 0, 0);
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            step(0, 0, 0, 0);
            n = k;
            if (state_out == 3'd4) break;
        end
        check("t4_wait_len", n, TIMEOUT);
        check("t4_err", 32'(err), 1);
        press(5);
        check("t4_op_a", 32'(op_a), 5);
        check("t4_err_clr", 32'(err), 0);

        // clear aborts WAIT; clear beats coincident add_done
        press(11);
        press(3); press(10); press(4); press(10);
        idle(3);
        press(11);
        step(0, 0, 1, 77);
        check("t5_state", 32'(state_out), 0);
        check("t5_result", 32'(result), 0);
        press(3); press(10); press(4); press(10);
        idle(2);
        step(1, 11, 1, 55);
        check("t5_clear_wins", 32'(result), 0);

        // asynchronous reset mid-entry and mid-wait
        press(1); press(2);
        async_reset();
        press(1); press(10); press(2); press(10);
        idle(2);
        async_reset();
        press(7); press(10); press(8); press(10);
        check("t6_op_a", 32'(op_a), 7);
        check("t6_op_b", 32'(op_b), 8);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 2047)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_entry_ctrl.md
Name: operand_entry_ctrl

Overview:
Sequencer between the keypad scanner and the adder datapath of the FPGA summing unit. It consumes decoded key events and builds two decimal operands in binary. It then launches one addition through a start/done handshake and selects the value shown on the display. It also owns clear, digit-limit and adder-timeout handling.

Parameters:
DIGITS, 3, max decimal digits per operand
WIDTH, 10, operand width in bits; must satisfy 10^DIGITS-1 < 2^WIDTH
TIMEOUT, 255, max cycles to wait for add_done after add_start (≥1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
key_valid  in  1  one-cycle pulse: key_code valid this cycle
key_code  in  4  0x0-0x9 digit, 0xA enter, 0xB clear, 0xC-0xF ignored
add_done  in  1  adder result valid (pulse or level, sampled only in WAIT)
sum_in  in  WIDTH+1  adder result
op_a  out  WIDTH  operand A to adder
op_b  out  WIDTH  operand B to adder
add_start  out  1  one-cycle launch pulse
result  out  WIDTH+1  latched sum
disp_value  out  WIDTH+1  value to display driver
state_out  out  3  encoded state for debug/LEDs
entry_full  out  1  current operand holds DIGITS digits
err  out  1  adder timeout flag, sticky until clear/new entry

Behaviour:
- Reset (asynchronous): state=ENTER_A. op_a=op_b=0, result=0, digit_cnt=0, add_start=0, err=0, timeout counter=0.
- All outputs are registered except disp_value and entry_full, which are combinational from registers.
- State encoding: ENTER_A=0, ENTER_B=1, START=2, WAIT=3, SHOW=4.
- All actions occur on the clk edge where key_valid=1. key_code is ignored when key_valid=0.
- Digit d in ENTER_A/ENTER_B:
  - If digit_cnt<DIGITS: the current operand becomes operand*10+d, computed as (x<<3)+(x<<1)+d in WIDTH bits. digit_cnt increments.
  - If digit_cnt==DIGITS: the key is ignored and the operand is unchanged.
- Enter (0xA):
  - ENTER_A with digit_cnt≥1: go to ENTER_B, op_b=0, digit_cnt=0.
  - ENTER_B with digit_cnt≥1: go to START.
  - digit_cnt==0: ignored.
  - START/WAIT/SHOW: ignored.
- Clear (0xB), any state: go to ENTER_A, op_a=op_b=result=0, digit_cnt=0, err=0, add_start=0. In WAIT this aborts; a later add_done is ignored.
- START: add_start=1 for exactly one cycle, op_a/op_b stable. Next cycle goes to WAIT with timeout counter=0. Non-clear keys are ignored.
- WAIT, each cycle:
  - add_done=1: result=sum_in, go to SHOW.
  - Else if counter==TIMEOUT-1: err=1, result unchanged, go to SHOW.
  - Otherwise counter increments.
  - Non-clear keys are ignored. If add_done and a clear key arrive in the same cycle, clear wins.
- SHOW: a digit d goes to ENTER_A with op_a=d, op_b=0, digit_cnt=1, err=0. Enter and 0xC-0xF are ignored. Results persist until then.
- op_a/op_b hold their values through START/WAIT/SHOW (no change except the transitions above).
- disp_value (zero-extended where needed):
  - ENTER_A: op_a
  - ENTER_B: op_b
  - START/WAIT: op_b
  - SHOW: result
- entry_full = (state is ENTER_A or ENTER_B) and digit_cnt==DIGITS.
- add_start never asserts outside START. Only one launch occurs per operand pair.

Test Plan:
1. Keys 1,2,3,A,4,5,A; adder model raises add_done 3 cycles after add_start with sum_in=168 -> single add_start pulse with op_a=123, op_b=45; state WAIT then SHOW; result=168; disp_value=168; err=0.
2. Keys 9,9,9,7 in ENTER_A -> op_a=999, entry_full=1 after third digit, fourth key ignored. Then A,0,A -> op_b=0, add_start pulses.
3. Enter pressed with no digits in ENTER_A and in ENTER_B -> state unchanged, no add_start. Keys 0xC-0xF in all states -> no effect.
4. Launch with add_done held low, TIMEOUT=255 -> SHOW entered exactly 255 cycles after entering WAIT, err=1, result unchanged. Next digit 5 -> ENTER_A, op_a=5, err=0.
5. Clear during WAIT, then add_done arrives -> state ENTER_A, all operands and result 0, add_done ignored. Clear coincident with add_done -> clear wins.
6. Assert rst asynchronously mid-entry (op_a=12) and mid-WAIT -> outputs go to reset values immediately, without waiting for a clk edge. After release, entry of 7,A,8,A gives op_a=7, op_b=8.
